// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file write-back arbiter with round-robin priority and x0 suppression.
// Optional busy-bit scoreboard compiled in with `define REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [4:0]           a_rd,
  input  logic [DATAWIDTH-1:0] a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [4:0]           b_rd,
  input  logic [DATAWIDTH-1:0] b_data,
  output logic                 wr_en,
  output logic [4:0]           wr_addr,
  output logic [DATAWIDTH-1:0] wr_data,
  output logic                 grant_b
`ifdef REGFILE_WB_SCOREBOARD_EN
  ,
  input  logic                 rsv_en,
  input  logic [4:0]           rsv_rd,
  output logic [31:0]          busy
`endif
);

  typedef struct packed {
    logic [4:0]           rd;
    logic [DATAWIDTH-1:0] data;
  } wbReq_t;

  logic   prio;      // 0 favours A, 1 favours B
  logic   xferA, xferB, xfer;
  wbReq_t selReq;

  // Readies depend only on valids, priority and reset; data/rd never gate the handshake.
  always_comb begin
    a_ready = !rst && a_valid && (!b_valid || !prio);
    b_ready = !rst && b_valid && (!a_valid ||  prio);
  end

  always_comb begin
    xferA  = a_valid && a_ready;
    xferB  = b_valid && b_ready;
    xfer   = xferA || xferB;
    selReq = xferB ? wbReq_t'{rd: b_rd, data: b_data}
                   : wbReq_t'{rd: a_rd, data: a_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      prio    <= 1'b0;
      grant_b <= 1'b0;
    end else begin
      // x0 writes complete the handshake but never reach the register file.
      wr_en <= xfer && (selReq.rd != 5'd0);
      if (xfer && (selReq.rd != 5'd0)) begin
        wr_addr <= selReq.rd;
        wr_data <= selReq.data;
      end
      if (xfer) begin
        prio    <= xferA;
        grant_b <= xferB;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  // A reservation on the same edge as a retiring write to that register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (rsv_en && (rsv_rd == i[4:0]))
          busy[i] <= 1'b1;
        else if (xfer && (selReq.rd == i[4:0]))
          busy[i] <= 1'b0;
      end
      busy[0] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, scoreboard corners, random vs model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        grant_b;
`ifdef REGFILE_WB_SCOREBOARD_EN
  logic        rsv_en;
  logic [4:0]  rsv_rd;
  logic [31:0] busy;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_b(grant_b)
`ifdef REGFILE_WB_SCOREBOARD_EN
    , .rsv_en(rsv_en), .rsv_rd(rsv_rd), .busy(busy)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who is next in line, plus the last register-file write seen.
  logic        mFavourB;
  logic        mEn, mGb;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic [31:0] mBusy;
  logic        sAr, sBr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check readies before the edge, check registers after it.
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic re, input logic [4:0] rr);
    logic winA, winB;
    logic [4:0] wrd;
    @(negedge clk);
    rst = r; a_valid = av; a_rd = ard; a_data = ad; b_valid = bv; b_rd = brd; b_data = bd;
`ifdef REGFILE_WB_SCOREBOARD_EN
    rsv_en = re; rsv_rd = rr;
`endif
    #1;
    // Winner: the lone requester, or the favoured one when both ask; nobody during reset.
    winA = !r && av && (!bv || !mFavourB);
    winB = !r && bv && (!av ||  mFavourB);
    chk("a_ready", {31'd0, a_ready}, {31'd0, winA});
    chk("b_ready", {31'd0, b_ready}, {31'd0, winB});
    sAr = a_ready; sBr = b_ready;
    @(posedge clk);
    #1;
    wrd = winB ? brd : ard;
    if (r) begin
      mEn = 0; mAddr = 0; mData = 0; mGb = 0; mFavourB = 0; mBusy = 0;
    end else begin
      mEn = 0;
      if (winA || winB) begin
        mGb = winB;
        mFavourB = winA;
        if (wrd != 0) begin
          mEn = 1; mAddr = wrd; mData = winB ? bd : ad;
        end
        mBusy[wrd] = 1'b0;
      end
      if (re && rr != 0) mBusy[rr] = 1'b1;
      mBusy[0] = 1'b0;
    end
    chk("wr_en",   {31'd0, wr_en},   {31'd0, mEn});
    chk("wr_addr", {27'd0, wr_addr}, {27'd0, mAddr});
    chk("wr_data", wr_data, mData);
    chk("grant_b", {31'd0, grant_b}, {31'd0, mGb});
`ifdef REGFILE_WB_SCOREBOARD_EN
    chk("busy", busy, mBusy);
`endif
  endtask

  typedef struct {
    logic        r, av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        ear, ebr, ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        egb;
  } vec_t;

  vec_t vecs[13];

  logic        pA, pB;
  logic [4:0]  pArd, pBrd;
  logic [31:0] pAd, pBd;

  initial begin
    //                r  av ard   ad            bv brd   bd         ar br we wa    wd            gb
    vecs[0]  = '{1'b1,1'b1,5'd0,32'h0,        1'b1,5'd0,32'h0,     0,0,0,5'd0,32'h0,        0};
    vecs[1]  = '{1'b0,1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,     1,0,1,5'd5,32'hDEADBEEF, 0};
    vecs[2]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     0,0,0,5'd5,32'hDEADBEEF, 0};
    vecs[3]  = '{1'b1,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     0,0,0,5'd0,32'h0,        0};
    vecs[4]  = '{1'b0,1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1,0,1,5'd1,32'h11,       0};
    vecs[5]  = '{1'b0,1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    0,1,1,5'd2,32'h22,       1};
    vecs[6]  = '{1'b0,1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1,0,1,5'd1,32'h11,       0};
    vecs[7]  = '{1'b0,1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    0,1,1,5'd2,32'h22,       1};
    vecs[8]  = '{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd0,32'h55,    0,1,0,5'd2,32'h22,       1};
    vecs[9]  = '{1'b0,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    1,0,1,5'd3,32'h33,       0};
    vecs[10] = '{1'b1,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    0,0,0,5'd0,32'h0,        0};
    vecs[11] = '{1'b0,1'b1,5'd3,32'h33,       1'b1,5'd4,32'h44,    1,0,1,5'd3,32'h33,       0};
    vecs[12] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     0,0,0,5'd3,32'h33,       0};

    rst = 1; a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    rsv_en = 0; rsv_rd = 0;
`endif
    mFavourB = 0; mEn = 0; mGb = 0; mAddr = 0; mData = 0; mBusy = 0;

    // Directed table: single request, alternation, x0 suppression, reset cancelling a write.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].r, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].bv, vecs[i].brd, vecs[i].bd, 1'b0, 5'd0);
      chk($sformatf("v%0d.a_ready", i), {31'd0, sAr}, {31'd0, vecs[i].ear});
      chk($sformatf("v%0d.b_ready", i), {31'd0, sBr}, {31'd0, vecs[i].ebr});
      chk($sformatf("v%0d.wr_en", i),   {31'd0, wr_en},   {31'd0, vecs[i].ewe});
      chk($sformatf("v%0d.wr_addr", i), {27'd0, wr_addr}, {27'd0, vecs[i].ewa});
      chk($sformatf("v%0d.wr_data", i), wr_data, vecs[i].ewd);
      chk($sformatf("v%0d.grant_b", i), {31'd0, grant_b}, {31'd0, vecs[i].egb});
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    chk("sb.set7", {31'd0, busy[7]}, 32'd1);
    step(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
    chk("sb.clr7", {31'd0, busy[7]}, 32'd0);
    step(0, 1, 5'd7, 32'h78, 0, 0, 0, 1, 5'd7);
    chk("sb.setwins7", {31'd0, busy[7]}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
    chk("sb.x0", {31'd0, busy[0]}, 32'd0);
`endif

    // Random traffic: each requester holds its request until accepted, as a real unit would.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    pA = 0; pB = 0; pArd = 0; pBrd = 0; pAd = 0; pBd = 0;
    for (int c = 0; c < 400; c++) begin
      logic r, re;
      logic [4:0] rr;
      if (!pA && $urandom_range(0, 2) != 0) begin
        pA = 1; pArd = 5'($urandom_range(0, 7)); pAd = $urandom;
      end
      if (!pB && $urandom_range(0, 2) != 0) begin
        pB = 1; pBrd = 5'($urandom_range(0, 7)); pBd = $urandom;
      end
      r  = ($urandom_range(0, 39) == 0);
      re = $urandom_range(0, 1) == 1;
      rr = 5'($urandom_range(0, 7));
      step(r, pA, pArd, pAd, pB, pBrd, pBd, re, rr);
      if (sAr) pA = 0;
      if (sBr) pB = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
